regex_stream_ctx: RTL and testbench

Parametrised per-stream context manager for one DPI regex matcher engine. Saves and restores the engine state per stream ID, tracks stream validity internally, and records a speculative per-packet match. At EOP it commits per-stream saturating match counts plus a global total, and exposes a count readback port with optional clear-on-read. It sits between the packet parser and one matcher instance, which connects via the state_in/state_out/accept_out ports.

---
 rtl/regex_ctx_pkg.sv | 20 ++
 rtl/regex_ctx_cnt_bank.sv | 66 ++++++
 rtl/regex_stream_ctx.sv | 156 +++++++++++++++
 tb/tb_regex_stream_ctx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regex_ctx_pkg.sv
// Shared types and helpers for the regex stream context manager.
package regex_ctx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_COMMIT = 2'd3
   } ctx_state_e;

   // Increment that sticks at max_value instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
      if (value >= max_value) begin
         return value;
      end else begin
         return value + 32'd1;
      end
   endfunction

endpackage

// File: rtl/regex_ctx_cnt_bank.sv
// Per-stream saturating match counters with commit-increment, read/clear and bulk clear.
module regex_ctx_cnt_bank
   import regex_ctx_pkg::*;
#(
   parameter int NUM_STREAMS = 64,
   parameter int SID_W       = $clog2(NUM_STREAMS),
   parameter int CNT_W       = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clear_all,
   input  logic             i_inc,
   input  logic [SID_W-1:0] i_inc_sid,
   input  logic             i_rd_en,
   input  logic             i_rd_clr,
   input  logic [SID_W-1:0] i_rd_sid,
   output logic             o_rd_vld,
   output logic [CNT_W-1:0] o_rd_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] r_cnt  [NUM_STREAMS];
   logic [CNT_W-1:0] w_base [NUM_STREAMS];
   logic [CNT_W-1:0] w_nxt  [NUM_STREAMS];
   logic             r_rd_vld;
   logic [CNT_W-1:0] r_rd_count;

   // A read-clear and a commit on the same stream: clear first, then count the new hit.
   always_comb begin
      for (int i = 0; i < NUM_STREAMS; i++) begin
         if (i_rd_en && i_rd_clr && (i_rd_sid == SID_W'(i))) begin
            w_base[i] = '0;
         end else begin
            w_base[i] = r_cnt[i];
         end
         if (i_inc && (i_inc_sid == SID_W'(i))) begin
            w_nxt[i] = CNT_W'(sat_inc(32'(w_base[i]), 32'(CNT_MAX)));
         end else begin
            w_nxt[i] = w_base[i];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < NUM_STREAMS; i++) begin
            r_cnt[i] <= '0;
         end
         r_rd_vld   <= 1'b0;
         r_rd_count <= '0;
      end else begin
         r_rd_vld <= i_rd_en;
         if (i_rd_en) begin
            r_rd_count <= i_clear_all ? '0 : r_cnt[i_rd_sid];
         end
         for (int i = 0; i < NUM_STREAMS; i++) begin
            r_cnt[i] <= i_clear_all ? '0 : w_nxt[i];
         end
      end
   end

   assign o_rd_vld   = r_rd_vld;
   assign o_rd_count = r_rd_count;

endmodule

// File: rtl/regex_stream_ctx.sv
// Per-stream save/restore of matcher state with speculative match tracking and
// committed saturating per-stream and total match counts.
module regex_stream_ctx
   import regex_ctx_pkg::*;
#(
   parameter int STATE_W     = 11,
   parameter int NUM_STREAMS = 64,
   parameter int SID_W       = $clog2(NUM_STREAMS),
   parameter int CNT_W       = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_load_state,
   output logic               o_load_rdy,
   input  logic [SID_W-1:0]   i_stream_id,
   input  logic               i_new_stream_id,
   input  logic               i_eop,
   input  logic               i_enable,
   input  logic               i_clear_all,
   output logic [STATE_W-1:0] o_state_in,
   output logic               o_state_in_vld,
   input  logic [STATE_W-1:0] i_state_out,
   input  logic               i_accept_out,
   output logic               o_fired,
   output logic               o_commit_vld,
   output logic               o_commit_hit,
   input  logic               i_rd_req,
   input  logic [SID_W-1:0]   i_rd_sid,
   input  logic               i_rd_clr,
   output logic               o_rd_rdy,
   output logic               o_rd_vld,
   output logic [CNT_W-1:0]   o_rd_count,
   output logic [CNT_W-1:0]   o_total_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   ctx_state_e         r_state;
   logic [SID_W-1:0]   r_sid;
   logic [NUM_STREAMS-1:0] r_valid;
   logic               r_fired;
   logic               r_state_in_vld;
   logic               r_commit_vld;
   logic               r_commit_hit;
   logic [CNT_W-1:0]   r_total;
   logic [STATE_W-1:0] r_state_in;
   logic [STATE_W-1:0] r_state_mem [NUM_STREAMS];

   logic w_load_rdy, w_rd_rdy, w_load_acc, w_eop_acc, w_commit, w_hit, w_fresh;

   assign w_load_rdy = (r_state != ST_COMMIT) && !i_clear_all;
   assign w_rd_rdy   = (r_state != ST_COMMIT);
   assign w_load_acc = i_load_state && w_load_rdy && ((r_state == ST_IDLE) || (r_state == ST_ACTIVE));
   // A load in the same cycle as eop abandons the packet rather than committing it.
   assign w_eop_acc  = i_eop && !i_clear_all && !w_load_acc && (r_state == ST_ACTIVE);
   assign w_commit   = w_eop_acc && i_enable;
   assign w_hit      = r_fired || i_accept_out;
   assign w_fresh    = i_new_stream_id || !r_valid[i_stream_id];

   // Control FSM, validity bits, fired flag, commit pulses and total count.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state        <= ST_IDLE;
         r_sid          <= '0;
         r_valid        <= '0;
         r_fired        <= 1'b0;
         r_state_in_vld <= 1'b0;
         r_commit_vld   <= 1'b0;
         r_commit_hit   <= 1'b0;
         r_total        <= '0;
      end else begin
         r_state_in_vld <= 1'b0;
         r_commit_vld   <= 1'b0;
         r_commit_hit   <= 1'b0;
         if (i_clear_all) begin
            r_state <= ST_IDLE;
            r_valid <= '0;
            r_fired <= 1'b0;
            r_total <= '0;
         end else if (w_load_acc) begin
            r_state        <= ST_LOAD;
            r_sid          <= i_stream_id;
            r_fired        <= 1'b0;
            r_state_in_vld <= 1'b1;
         end else begin
            case (r_state)
               ST_IDLE:   r_state <= ST_IDLE;
               ST_LOAD:   r_state <= ST_ACTIVE;
               ST_ACTIVE: begin
                  if (w_eop_acc) begin
                     r_state <= ST_COMMIT;
                     if (i_enable) begin
                        r_valid[r_sid] <= 1'b1;
                        r_fired        <= w_hit;
                        r_commit_vld   <= 1'b1;
                        r_commit_hit   <= w_hit;
                        if (w_hit) begin
                           r_total <= CNT_W'(sat_inc(32'(r_total), 32'(CNT_MAX)));
                        end
                     end else begin
                        r_fired <= 1'b0;
                     end
                  end else if (i_accept_out) begin
                     r_fired <= 1'b1;
                  end
               end
               ST_COMMIT: r_state <= ST_IDLE;
               default:   r_state <= ST_IDLE;
            endcase
         end
      end
   end

   // Context store; contents are meaningful only where the valid bit is set.
   always_ff @(posedge i_clk) begin
      if (w_commit && !i_rst) begin
         r_state_mem[r_sid] <= i_state_out;
      end
   end

   // Registered restore path to the matcher.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state_in <= '0;
      end else if (w_load_acc) begin
         r_state_in <= w_fresh ? '0 : r_state_mem[i_stream_id];
      end
   end

   regex_ctx_cnt_bank #(
      .NUM_STREAMS (NUM_STREAMS),
      .SID_W       (SID_W),
      .CNT_W       (CNT_W)
   ) u_cnt_bank (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_clear_all (i_clear_all),
      .i_inc       (w_commit && w_hit),
      .i_inc_sid   (r_sid),
      .i_rd_en     (i_rd_req && w_rd_rdy),
      .i_rd_clr    (i_rd_clr),
      .i_rd_sid    (i_rd_sid),
      .o_rd_vld    (o_rd_vld),
      .o_rd_count  (o_rd_count)
   );

   assign o_load_rdy     = w_load_rdy;
   assign o_rd_rdy       = w_rd_rdy;
   assign o_state_in     = r_state_in;
   assign o_state_in_vld = r_state_in_vld;
   assign o_fired        = r_fired;
   assign o_commit_vld   = r_commit_vld;
   assign o_commit_hit   = r_commit_hit;
   assign o_total_count  = r_total;

endmodule

// File: tb/tb_regex_stream_ctx.sv
// Directed self-checking bench for regex_stream_ctx (CNT_W reduced to 8 so saturation is reachable).
module tb_regex_stream_ctx;

   localparam int STATE_W     = 11;
   localparam int NUM_STREAMS = 64;
   localparam int SID_W       = 6;
   localparam int CNT_W       = 8;

   logic               i_clk = 1'b0;
   logic               i_rst = 1'b1;
   logic               i_load_state = 1'b0;
   logic               o_load_rdy;
   logic [SID_W-1:0]   i_stream_id = '0;
   logic               i_new_stream_id = 1'b0;
   logic               i_eop = 1'b0;
   logic               i_enable = 1'b0;
   logic               i_clear_all = 1'b0;
   logic [STATE_W-1:0] o_state_in;
   logic               o_state_in_vld;
   logic [STATE_W-1:0] i_state_out = '0;
   logic               i_accept_out = 1'b0;
   logic               o_fired;
   logic               o_commit_vld;
   logic               o_commit_hit;
   logic               i_rd_req = 1'b0;
   logic [SID_W-1:0]   i_rd_sid = '0;
   logic               i_rd_clr = 1'b0;
   logic               o_rd_rdy;
   logic               o_rd_vld;
   logic [CNT_W-1:0]   o_rd_count;
   logic [CNT_W-1:0]   o_total_count;

   int checks = 0;
   int errors = 0;

   regex_stream_ctx #(
      .STATE_W     (STATE_W),
      .NUM_STREAMS (NUM_STREAMS),
      .SID_W       (SID_W),
      .CNT_W       (CNT_W)
   ) dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_load_state    (i_load_state),
      .o_load_rdy      (o_load_rdy),
      .i_stream_id     (i_stream_id),
      .i_new_stream_id (i_new_stream_id),
      .i_eop           (i_eop),
      .i_enable        (i_enable),
      .i_clear_all     (i_clear_all),
      .o_state_in      (o_state_in),
      .o_state_in_vld  (o_state_in_vld),
      .i_state_out     (i_state_out),
      .i_accept_out    (i_accept_out),
      .o_fired         (o_fired),
      .o_commit_vld    (o_commit_vld),
      .o_commit_hit    (o_commit_hit),
      .i_rd_req        (i_rd_req),
      .i_rd_sid        (i_rd_sid),
      .i_rd_clr        (i_rd_clr),
      .o_rd_rdy        (o_rd_rdy),
      .o_rd_vld        (o_rd_vld),
      .o_rd_count      (o_rd_count),
      .o_total_count   (o_total_count)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL timeout observed no finish expected finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load_pkt(input logic [SID_W-1:0] sid, input logic nw, input logic [31:0] exp_state);
      i_load_state    = 1'b1;
      i_stream_id     = sid;
      i_new_stream_id = nw;
      tick();
      i_load_state    = 1'b0;
      i_new_stream_id = 1'b0;
      chk("state_in_vld", 32'(o_state_in_vld), 32'd1);
      chk("state_in", 32'(o_state_in), exp_state);
   endtask

   task automatic pkt_end(input logic en, input logic acc, input logic [STATE_W-1:0] sout,
                          input logic [31:0] exp_cv, input logic [31:0] exp_hit);
      i_eop        = 1'b1;
      i_enable     = en;
      i_accept_out = acc;
      i_state_out  = sout;
      tick();
      i_eop        = 1'b0;
      i_enable     = 1'b0;
      i_accept_out = 1'b0;
      chk("commit_vld", 32'(o_commit_vld), exp_cv);
      if (exp_cv == 32'd1) begin
         chk("commit_hit", 32'(o_commit_hit), exp_hit);
      end
   endtask

   task automatic rd(input logic [SID_W-1:0] sid, input logic clr, input logic [31:0] exp_cnt);
      i_rd_req = 1'b1;
      i_rd_sid = sid;
      i_rd_clr = clr;
      tick();
      i_rd_req = 1'b0;
      i_rd_clr = 1'b0;
      chk("rd_vld", 32'(o_rd_vld), 32'd1);
      chk("rd_count", 32'(o_rd_count), exp_cnt);
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      i_rst = 1'b0;
      tick();
      chk("rst_fired", 32'(o_fired), 32'd0);
      chk("rst_state_in_vld", 32'(o_state_in_vld), 32'd0);
      chk("rst_commit_vld", 32'(o_commit_vld), 32'd0);
      chk("rst_rd_vld", 32'(o_rd_vld), 32'd0);
      chk("rst_total", 32'(o_total_count), 32'd0);
      chk("rst_state_in", 32'(o_state_in), 32'd0);
      chk("rst_load_rdy", 32'(o_load_rdy), 32'd1);
      chk("rst_rd_rdy", 32'(o_rd_rdy), 32'd1);

      // First packet on fresh stream 5 with one accept
      load_pkt(6'd5, 1'b0, 32'h0);
      tick();
      chk("state_in_vld_pulse", 32'(o_state_in_vld), 32'd0);
      i_accept_out = 1'b1;
      tick();
      i_accept_out = 1'b0;
      chk("fired_set", 32'(o_fired), 32'd1);
      tick();
      chk("fired_sticky", 32'(o_fired), 32'd1);
      pkt_end(1'b1, 1'b0, 11'h111, 32'd1, 32'd1);
      chk("commit_load_rdy", 32'(o_load_rdy), 32'd0);
      chk("commit_rd_rdy", 32'(o_rd_rdy), 32'd0);
      chk("total_1", 32'(o_total_count), 32'd1);
      tick();
      rd(6'd5, 1'b0, 32'd1);

      // Second packet restores saved state, no match
      load_pkt(6'd5, 1'b0, 32'h111);
      tick();
      pkt_end(1'b1, 1'b0, 11'h2A3, 32'd1, 32'd0);
      tick();
      load_pkt(6'd5, 1'b0, 32'h2A3);
      tick();
      load_pkt(6'd5, 1'b1, 32'h0);
      tick();
      rd(6'd5, 1'b0, 32'd1);

      // Disabled commit leaves context and count untouched
      i_accept_out = 1'b1;
      tick();
      i_accept_out = 1'b0;
      pkt_end(1'b0, 1'b0, 11'h3FF, 32'd0, 32'd0);
      chk("disabled_fired", 32'(o_fired), 32'd0);
      tick();
      load_pkt(6'd5, 1'b0, 32'h2A3);
      tick();
      rd(6'd5, 1'b0, 32'd1);
      chk("total_after_disabled", 32'(o_total_count), 32'd1);

      // Bring stream 3 to 0xFE with same-cycle accepts; total reaches 0xFF
      for (int k = 0; k < 254; k++) begin
         load_pkt(6'd3, 1'b0, (k == 0) ? 32'h0 : 32'h033);
         tick();
         pkt_end(1'b1, 1'b1, 11'h033, 32'd1, 32'd1);
         tick();
      end
      rd(6'd3, 1'b0, 32'hFE);
      chk("total_sat_reach", 32'(o_total_count), 32'hFF);
      for (int k = 0; k < 2; k++) begin
         load_pkt(6'd3, 1'b0, 32'h033);
         tick();
         pkt_end(1'b1, 1'b1, 11'h033, 32'd1, 32'd1);
         tick();
         rd(6'd3, 1'b0, 32'hFF);
         chk("total_sat_hold", 32'(o_total_count), 32'hFF);
      end

      // Read-clear during COMMIT is dropped; held request completes afterwards
      load_pkt(6'd5, 1'b0, 32'h2A3);
      tick();
      i_accept_out = 1'b1;
      tick();
      i_accept_out = 1'b0;
      pkt_end(1'b1, 1'b0, 11'h155, 32'd1, 32'd1);
      i_rd_req = 1'b1;
      i_rd_sid = 6'd5;
      i_rd_clr = 1'b1;
      #1;
      chk("rd_rdy_commit", 32'(o_rd_rdy), 32'd0);
      tick();
      chk("rd_dropped", 32'(o_rd_vld), 32'd0);
      tick();
      i_rd_req = 1'b0;
      i_rd_clr = 1'b0;
      chk("rd_retry_vld", 32'(o_rd_vld), 32'd1);
      chk("rd_retry_count", 32'(o_rd_count), 32'd2);
      rd(6'd5, 1'b0, 32'd0);

      // clear_all mid-packet
      load_pkt(6'd5, 1'b0, 32'h155);
      tick();
      i_accept_out = 1'b1;
      tick();
      i_accept_out = 1'b0;
      i_clear_all = 1'b1;
      #1;
      chk("clear_load_rdy", 32'(o_load_rdy), 32'd0);
      tick();
      i_clear_all = 1'b0;
      chk("clear_fired", 32'(o_fired), 32'd0);
      chk("clear_total", 32'(o_total_count), 32'd0);
      i_eop    = 1'b1;
      i_enable = 1'b1;
      tick();
      i_eop    = 1'b0;
      i_enable = 1'b0;
      chk("clear_idle_eop", 32'(o_commit_vld), 32'd0);
      rd(6'd3, 1'b0, 32'd0);
      load_pkt(6'd5, 1'b0, 32'h0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
